// File: rtl/iterative_divider.sv
// Radix-2 restoring divider with Busy stall handshake, sits beside the ALU multiplier.
// Optional DIV_FASTPATH_EN: skip iterations when |dividend| < |divisor|.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK_MUL,
  input  logic             Reset,
  input  logic             DIV_EN,
  input  logic             DIVOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic             op_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] remo_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [WIDTH:0]   sh_rem_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dq_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] r_fix_d;

  always_comb begin
    mag_a_d  = (DIVOp & Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    mag_b_d  = (DIVOp & Operand2[WIDTH-1]) ? -Operand2 : Operand2;
    sh_rem_d = {rem_q, dq_q[WIDTH-1]};
    diff_d   = sh_rem_d - {1'b0, dvs_q};
    // Negative trial difference means restore the shifted remainder
    rem_d    = diff_d[WIDTH] ? sh_rem_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
    dq_d     = {dq_q[WIDTH-2:0], ~diff_d[WIDTH]};
    q_fix_d  = (op_q & (sa_q ^ sb_q)) ? -dq_q : dq_q;
    r_fix_d  = (op_q & sa_q) ? -rem_q : rem_q;
  end

  assign Busy = ~Reset & ((state_q == IDLE & DIV_EN) |
                          state_q == RUN | state_q == FIX);
  assign Quotient  = quo_q;
  assign Remainder = remo_q;

  always_ff @(posedge CLK_MUL) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DIV_EN) begin
            op_q  <= DIVOp;
            sa_q  <= Operand1[WIDTH-1];
            sb_q  <= Operand2[WIDTH-1];
            cnt_q <= '0;
            dvs_q <= mag_b_d;
            if (Operand2 == '0) begin
              // Clearing op_q makes FIX pass the raw divide-by-zero result
              op_q    <= 1'b0;
              dq_q    <= '1;
              rem_q   <= Operand1;
              state_q <= FIX;
            end
`ifdef DIV_FASTPATH_EN
            else if (mag_a_d < mag_b_d) begin
              dq_q    <= '0;
              rem_q   <= mag_a_d;
              state_q <= FIX;
            end
`endif
            else begin
              dq_q    <= mag_a_d;
              rem_q   <= '0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!DIV_EN) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= FIX;
          end
        end
        FIX: begin
          if (!DIV_EN) begin
            state_q <= IDLE;
          end else begin
            quo_q   <= q_fix_d;
            remo_q  <= r_fix_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!DIV_EN) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider.
// Expected Busy length follows DIV_FASTPATH_EN for the fast-path vector.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  iterative_divider #(.WIDTH(32)) dut (
    .CLK_MUL  (clk),
    .Reset    (rst),
    .DIV_EN   (en),
    .DIVOp    (op),
    .Operand1 (a),
    .Operand2 (b),
    .Quotient (q),
    .Remainder(r),
    .Busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Starts a divide, scrambles inputs after the latch edge, checks result.
  task automatic run_div(string tag, logic o, logic [31:0] x,
                         logic [31:0] y, int exp_n,
                         logic [31:0] eq, logic [31:0] er);
    int n;
    int b0;
    op = o;
    a  = x;
    b  = y;
    en = 1'b1;
    @(negedge clk);
    b0 = busy ? 1 : 0;
    @(posedge clk);
    #1;
    a  = ~x;
    b  = y ^ 32'h5;
    op = ~o;
    wait_busy(n);
    check({tag, "_busy"}, 32'(b0 + n), 32'(exp_n));
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int fp_n;
  int n;
  int b0;

  initial begin
`ifdef DIV_FASTPATH_EN
    fp_n = 2;
`else
    fp_n = 34;
`endif
    rst = 1'b1;
    en  = 1'b1;
    op  = 1'b0;
    a   = 32'd5;
    b   = 32'd1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2);
    run_div("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
            32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34,
            32'hFFFF_FFFD, 32'd1);
    run_div("udz", 1'b0, 32'h1234, 32'd0, 2,
            32'hFFFF_FFFF, 32'h1234);
    run_div("sdz", 1'b1, 32'h1234, 32'd0, 2,
            32'hFFFF_FFFF, 32'h1234);
    run_div("sdzneg", 1'b1, 32'hFFFF_FFF9, 32'd0, 2,
            32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
            32'h8000_0000, 32'd0);
    run_div("u3_10", 1'b0, 32'd3, 32'd10, fp_n, 32'd0, 32'd3);

    // Abort: drop request in cycle T+10
    op = 1'b0;
    a  = 32'd100;
    b  = 32'd7;
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    check("abort_run_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", q, 32'd0);
    check("abort_r", r, 32'd3);
    @(posedge clk);
    #1;
    run_div("u9_4", 1'b0, 32'd9, 32'd4, 34, 32'd2, 32'd1);

    // Reset in the middle of a divide
    op = 1'b0;
    a  = 32'd100;
    b  = 32'd7;
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy0", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_q", q, 32'd0);
    check("midrst_r", r, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    b0 = busy ? 1 : 0;
    wait_busy(n);
    check("restart_busy", 32'(b0 + n), 32'd34);
    check("restart_q", q, 32'd14);
    check("restart_r", r, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_q", q, 32'd14);
      check("hold_r", r, 32'd2);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
